axis2mat_unpack: RTL and testbench
==================================

Name: axis2mat_unpack

Overview:
- Receive side of the Mat-to-AXI-stream packer. Reads contiguously packed 64-bit words from the ldata FIFO and unpacks them into 24-bit pixels, one per in_mat_data FIFO write, for a rows x cols frame.
- Sits at the input of the pp_pipeline dataflow region, ahead of the processing kernels.
- Uses the same ap_ctrl_chain block handshake as the other dataflow processes.

Parameters:
- PIX_W, 24, pixel width in bits (one pixel per beat, NPC=1).
- WORD_W, 64, packed stream word width; must satisfy WORD_W >= PIX_W.
- BUF_W, PIX_W+WORD_W, residue buffer width; derived, not to be overridden.

Ports:
- ap_clk  in  1  single clock; all logic on the rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- ap_start  in  1  start request; rows/cols are valid while it is high.
- ap_ready  out  1  one-cycle pulse when rows/cols are latched.
- ap_done  out  1  frame complete; held until ap_continue.
- ap_idle  out  1  high in IDLE only.
- ap_continue  in  1  acknowledges ap_done.
- rows  in  16  frame height; sampled on start.
- cols  in  32  frame width in pixels; sampled on start.
- ldata_dout  in  WORD_W  packed word, FWFT.
- ldata_empty_n  in  1  word available.
- ldata_read  out  1  pop ldata.
- in_mat_data_din  out  PIX_W  unpacked pixel.
- in_mat_data_full_n  in  1  pixel FIFO has space.
- in_mat_data_write  out  1  push pixel.

Behaviour:
- Reset (async on ap_rst_n low): state=IDLE; ap_ready=0, ap_done=0, ap_idle=1, ldata_read=0, in_mat_data_write=0, in_mat_data_din=0; buffer, bit count and row/col counters cleared. Reset asserted mid-frame aborts the frame; no further reads or writes.
- Packing format:
  - Pixel k occupies bits [PIX_W*k+PIX_W-1 : PIX_W*k] of the concatenated stream; word j supplies stream bits [WORD_W*j+WORD_W-1 : WORD_W*j], little-endian.
  - Frame consumes ceil(PIX_W*rows*cols/WORD_W) words. Pad bits above the last pixel in the final word are discarded.
- FSM IDLE -> RUN -> DONE -> IDLE:
  - IDLE, ap_start=1: latch rows and cols, pulse ap_ready for 1 cycle, clear count, go to RUN next cycle.
  - IDLE with rows==0 or cols==0: go straight to DONE with zero reads.
  - RUN -> DONE in the cycle after the last pixel write.
  - DONE: ap_done=1 held. When ap_continue=1, go to IDLE on the next edge.
  - ap_start is ignored outside IDLE.
- RUN datapath, per cycle, with cnt = valid bits in buffer (bit 0 = oldest):
  - emit = (cnt>=PIX_W) & in_mat_data_full_n & pixels_left. On emit: din=buf[PIX_W-1:0], write=1, buffer shifts right by PIX_W, and the col counter increments (wrap to 0 at cols-1, row counter +1).
  - cnt_after = cnt - (emit?PIX_W:0); pixels_after = pixels remaining after this emit.
  - rd = ldata_empty_n & (cnt_after<PIX_W) & pixels_after. On rd: ldata_read=1 and ldata_dout is appended at bit position cnt_after; cnt = cnt_after + WORD_W.
  - Emit and read happen in the same cycle when both conditions hold. Sustained rate is 1 pixel/cycle when neither FIFO stalls.
  - cnt never exceeds PIX_W+WORD_W-1 (87).
- Outputs are registered.
  - First pixel is written 2 cycles after the first ldata read: read, then register.
  - in_mat_data_din holds its last value when write=0.
- Row counter is 16 bits, col counter 32 bits; end condition is row==rows-1 & col==cols-1. No 48-bit multiply.
- After the last pixel, leftover pad bits are dropped; cnt is cleared on entry to DONE.
- Back-pressure: full_n=0 stalls emit only; the buffer may still fill through rd until cnt_after>=PIX_W. empty_n=0 stalls reads only.

Decomposition:
- Shared package pp_stream_pkg: PIX_W, WORD_W and BUF_W constants; FSM state typedef (IDLE, RUN, DONE); counter width constants (ROWS_W=16, COLS_W=32). The packer uses the same package.
- One sub-module: axis2mat_bitbuf, holding the residue buffer, cnt, and the append/shift logic with emit/rd strobes.
- FSM and row/col counters stay in the top level.

Test Plan:
- rows=1, cols=8, words W0..W2 with incrementing bytes 0x00..0x17 -> exactly 3 ldata_read; pixels 0x020100, 0x050403, ... 0x171615 in order; ap_done asserted.
- rows=1, cols=3, 2 words -> 2 reads, 3 pixels. Pixel 2 = {W1[7:0], W0[63:48]}. W1[63:8] is discarded; cnt=0 in DONE.
- rows=0, cols=100 -> ap_ready pulse, then ap_done, with zero ldata_read and zero writes.
- rows=4, cols=16, full_n toggling 50% random and empty_n gaps -> 64 pixels match the golden model, 24 reads, no over-read. When unstalled, 1 pixel/cycle is sustained.
- ap_continue held low for 10 cycles after done -> ap_done stays 1, ap_idle stays 0, and a new ap_start is not accepted until the cycle after ap_continue=1.
- ap_rst_n pulsed low mid-frame after 5 pixels -> all outputs return to reset values immediately. The next frame (rows=1, cols=8) unpacks correctly from fresh words.

Source files
------------

// File: rtl/pp_stream_pkg.sv
// pp_stream_pkg: shared widths and block FSM state for the Mat/AXI-stream packer and unpacker
package pp_stream_pkg;
  localparam int PIX_W = 24;
  localparam int WORD_W = 64;
  localparam int BUF_W = PIX_W + WORD_W;
  localparam int CNT_W = $clog2(BUF_W);
  localparam int ROWS_W = 16;
  localparam int COLS_W = 32;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/axis2mat_bitbuf.sv
// axis2mat_bitbuf: residue bit buffer; pixels leave from bit 0, words append above the valid bits
module axis2mat_bitbuf
  import pp_stream_pkg::*;
(
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              clr,
  input  logic              emit,
  input  logic              rd,
  input  logic [WORD_W-1:0] word,
  output logic [PIX_W-1:0]  pix,
  output logic              avail,
  output logic              room
);
  logic [BUF_W-1:0] bits, shifted;
  logic [CNT_W-1:0] cnt, cnt_after;
  always_comb begin
    cnt_after = emit ? cnt - CNT_W'(PIX_W) : cnt;
    shifted = emit ? bits >> PIX_W : bits;
    pix = bits[PIX_W-1:0];
    avail = cnt >= CNT_W'(PIX_W);
    room = cnt_after < CNT_W'(PIX_W);
  end
  // bits above cnt are always zero, so a new word can be OR-ed in place
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      bits <= '0;
      cnt <= '0;
    end else if (clr) begin
      bits <= '0;
      cnt <= '0;
    end else begin
      bits <= rd ? shifted | (BUF_W'(word) << cnt_after) : shifted;
      cnt <= rd ? cnt_after + CNT_W'(WORD_W) : cnt_after;
    end
endmodule

// File: rtl/axis2mat_unpack.sv
// axis2mat_unpack: unpacks contiguously packed 64-bit ldata words into 24-bit pixels for a rows x cols frame
module axis2mat_unpack
  import pp_stream_pkg::*;
(
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_ready,
  output logic              ap_done,
  output logic              ap_idle,
  input  logic              ap_continue,
  input  logic [ROWS_W-1:0] rows,
  input  logic [COLS_W-1:0] cols,
  input  logic [WORD_W-1:0] ldata_dout,
  input  logic              ldata_empty_n,
  output logic              ldata_read,
  output logic [PIX_W-1:0]  in_mat_data_din,
  input  logic              in_mat_data_full_n,
  output logic              in_mat_data_write
);
  state_t state, nxt;
  logic [ROWS_W-1:0] rows_r, row;
  logic [COLS_W-1:0] cols_r, col;
  logic fin, last, col_end, emit, rd, avail, room, accept;
  logic [PIX_W-1:0] pix;
  always_comb begin
    accept = (state == IDLE) && ap_start;
    col_end = col == cols_r - COLS_W'(1);
    last = (row == rows_r - ROWS_W'(1)) && col_end;
    emit = (state == RUN) && avail && in_mat_data_full_n && !fin;
    rd = (state == RUN) && ldata_empty_n && room && !fin && !(emit && last);
    nxt = state == IDLE ? (ap_start ? ((rows == '0 || cols == '0) ? DONE : RUN) : IDLE) :
          state == RUN  ? (fin ? DONE : RUN) :
                          (ap_continue ? IDLE : DONE);
  end
  assign ldata_read = rd;
  axis2mat_bitbuf u_buf (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .clr      (state != RUN || fin),
    .emit     (emit),
    .rd       (rd),
    .word     (ldata_dout),
    .pix      (pix),
    .avail    (avail),
    .room     (room)
  );
  // fin marks that the last pixel has been emitted; the frame ends the following cycle
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      state <= IDLE;
      ap_ready <= 1'b0;
      ap_done <= 1'b0;
      ap_idle <= 1'b1;
      in_mat_data_write <= 1'b0;
      in_mat_data_din <= '0;
      rows_r <= '0;
      cols_r <= '0;
      row <= '0;
      col <= '0;
      fin <= 1'b0;
    end else begin
      state <= nxt;
      ap_ready <= accept;
      ap_done <= nxt == DONE;
      ap_idle <= nxt == IDLE;
      in_mat_data_write <= emit;
      if (emit) in_mat_data_din <= pix;
      if (accept) begin
        rows_r <= rows;
        cols_r <= cols;
        row <= '0;
        col <= '0;
        fin <= 1'b0;
      end else if (emit) begin
        col <= col_end ? '0 : col + COLS_W'(1);
        row <= col_end ? row + ROWS_W'(1) : row;
        fin <= last;
      end
    end
endmodule

// File: tb/tb_axis2mat_unpack.sv
// tb_axis2mat_unpack: randomized frames checked against a bit-stream reference of the packing format
module tb_axis2mat_unpack;
  logic ap_clk = 0, ap_rst_n = 0, ap_start = 0, ap_continue = 0;
  logic ap_ready, ap_done, ap_idle, ldata_read, in_mat_data_write;
  logic [15:0] rows = '0;
  logic [31:0] cols = '0;
  logic [63:0] ldata_dout = '0;
  logic ldata_empty_n = 0, in_mat_data_full_n = 1;
  logic [23:0] in_mat_data_din;
  int nvec = 0, nerr = 0;
  logic [63:0] fw[$];
  int src, nreads, npix, nready, first_wr, last_wr, cyc, exp_n, stall;
  bit pop;

  axis2mat_unpack dut (
    .ap_clk             (ap_clk),
    .ap_rst_n           (ap_rst_n),
    .ap_start           (ap_start),
    .ap_ready           (ap_ready),
    .ap_done            (ap_done),
    .ap_idle            (ap_idle),
    .ap_continue        (ap_continue),
    .rows               (rows),
    .cols               (cols),
    .ldata_dout         (ldata_dout),
    .ldata_empty_n      (ldata_empty_n),
    .ldata_read         (ldata_read),
    .in_mat_data_din    (in_mat_data_din),
    .in_mat_data_full_n (in_mat_data_full_n),
    .in_mat_data_write  (in_mat_data_write)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // pixel k is stream bits [24k+23:24k], word j holds stream bits [64j+63:64j]
  function automatic logic [23:0] pix_of(input int k);
    logic [23:0] p;
    logic [63:0] w;
    for (int b = 0; b < 24; b++) begin
      w = fw[(24 * k + b) / 64];
      p[b] = w[(24 * k + b) % 64];
    end
    return p;
  endfunction

  task automatic cycle();
    @(posedge ap_clk);
    #1;
    if (pop) src++;
    pop = 0;
    ldata_empty_n = (src < fw.size()) && (stall == 0 || $urandom_range(3) != 0);
    in_mat_data_full_n = (stall == 0) || ($urandom_range(1) == 1);
    ldata_dout = (src < fw.size()) ? fw[src] : 64'hdeadbeefdeadbeef;
    @(negedge ap_clk);
    cyc++;
    if (ap_ready) nready++;
    if (ldata_read) begin
      nreads++;
      pop = 1;
      check("rd_empty_n", ldata_empty_n, 1);
    end
    if (in_mat_data_write) begin
      if (npix < exp_n) check($sformatf("pix%0d", npix), in_mat_data_din, pix_of(npix));
      else check("extra_wr", npix, exp_n);
      if (npix == 0) first_wr = cyc;
      last_wr = cyc;
      npix++;
    end
  endtask

  task automatic run_frame(input int r, input int c, input int mode, input int hold, input int abort);
    int nw;
    nw = (24 * r * c + 63) / 64;
    fw.delete();
    for (int j = 0; j < nw; j++) begin
      logic [63:0] w;
      for (int b = 0; b < 8; b++) w[8*b +: 8] = 8'(8 * j + b);
      fw.push_back(mode == 0 ? w : {$urandom, $urandom});
    end
    src = 0; pop = 0; nreads = 0; npix = 0; nready = 0; exp_n = r * c;
    stall = (mode == 2) ? 1 : 0;
    rows = 16'(r);
    cols = 32'(c);
    ap_start = 1;
    cycle();
    ap_start = 0;
    for (int i = 0; i < 4000 && !ap_done && !(abort > 0 && npix >= abort); i++) cycle();
    if (abort > 0) begin
      ap_rst_n = 0;
      #1;
      check("rst_ready", ap_ready, 0);
      check("rst_done", ap_done, 0);
      check("rst_idle", ap_idle, 1);
      check("rst_read", ldata_read, 0);
      check("rst_write", in_mat_data_write, 0);
      check("rst_din", in_mat_data_din, 0);
      @(negedge ap_clk);
      ap_rst_n = 1;
      pop = 0;
      stall = 0;
      return;
    end
    check("done", ap_done, 1);
    check("ready_pulses", nready, 1);
    check("reads", nreads, nw);
    check("pixels", npix, exp_n);
    check("cnt_done", dut.u_buf.cnt, 0);
    if (mode != 2 && npix > 0) check("rate", last_wr - first_wr + 1, npix);
    if (hold > 0) begin
      ap_start = 1;
      rows = 16'd1;
      cols = 32'd8;
      for (int i = 0; i < hold; i++) begin
        cycle();
        check("hold_done", ap_done, 1);
        check("hold_idle", ap_idle, 0);
      end
      check("hold_no_start", nready, 1);
      ap_start = 0;
    end
    ap_continue = 1;
    cycle();
    ap_continue = 0;
    check("idle_after", ap_idle, 1);
    check("done_clear", ap_done, 0);
    check("no_late_reads", nreads, nw);
  endtask

  initial begin
    logic [63:0] w0, w1;
    repeat (3) @(negedge ap_clk);
    check("init_ready", ap_ready, 0);
    check("init_done", ap_done, 0);
    check("init_idle", ap_idle, 1);
    check("init_read", ldata_read, 0);
    check("init_write", in_mat_data_write, 0);
    check("init_din", in_mat_data_din, 0);
    ap_rst_n = 1;
    @(negedge ap_clk);
    run_frame(1, 8, 0, 0, 0);
    check("t1_last_pix", in_mat_data_din, 24'h171615);
    run_frame(1, 3, 1, 0, 0);
    w0 = fw[0];
    w1 = fw[1];
    check("t2_pix2", in_mat_data_din, {w1[7:0], w0[63:48]});
    run_frame(0, 100, 1, 0, 0);
    run_frame(5, 0, 1, 0, 0);
    run_frame(4, 16, 2, 0, 0);
    run_frame(2, 5, 1, 10, 0);
    run_frame(4, 16, 1, 0, 5);
    run_frame(1, 8, 0, 0, 0);
    check("t6_last_pix", in_mat_data_din, 24'h171615);
    for (int k = 0; k < 4; k++) run_frame($urandom_range(1, 3), $urandom_range(1, 12), 2, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
